full_subtractor: RTL and testbench
==================================

// Module: full_subtractor
//
// PURPOSE
//   Computes a - b - bin over WIDTH bits as a ripple-borrow subtractor.
//   Difference d and borrow-out bout are driven combinationally.
//   A registered copy with a valid flag is also provided for pipelined datapaths.
//   Default WIDTH=1 gives the classic single-bit full subtractor.
//
// PARAMETERS
//   WIDTH    1    operand/difference width in bits (>=1)
//
// PORTS
//   clk        in   1      single clock; all registers rise-edge triggered
//   rst_n      in   1      asynchronous, active-low reset
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in (weight 2^0)
//   d          out  WIDTH  combinational difference
//   bout       out  1      combinational borrow-out (1 = result went negative)
//   in_valid   in   1      qualifies a/b/bin for capture into the register stage
//   d_q        out  WIDTH  registered difference
//   bout_q     out  1      registered borrow-out
//   out_valid  out  1      d_q/bout_q hold a captured result
//
// BEHAVIOUR
//   - Clocking and reset: one clock; reset is asynchronous and active-low.
//   - Per bit i, with br[0]=bin:
//       d[i]    = a[i] ^ b[i] ^ br[i]
//       br[i+1] = (~a[i] & b[i]) | (~a[i] & br[i]) | (b[i] & br[i])
//       bout    = br[WIDTH]
//   - Equivalent check: {bout,d} == ({1'b0,a} - {1'b0,b} - bin) mod 2^(WIDTH+1),
//     where bout is the MSB (1 = borrow).
//   - d/bout: purely combinational, zero latency, independent of clk/rst_n.
//   - Register stage: on posedge clk with in_valid=1, d_q<=d, bout_q<=bout,
//     out_valid<=1. With in_valid=0, out_valid<=0 and d_q/bout_q hold.
//     Latency is 1 cycle. There is no backpressure.
//   - Reset values: d_q=0, bout_q=0, out_valid=0.
//   - Asserting rst_n=0 mid-stream clears the register stage immediately, with no clock edge.
//   - X/Z on inputs is not guarded; no internal state other than the register stage.
//
// CONFIGURATION
//   FULL_SUBTRACTOR_BORROW_CNT_EN
//     defined:
//       - adds output borrow_cnt [15:0], reset to 0.
//       - increments on each posedge with in_valid=1 and bout=1.
//       - saturates at 16'hFFFF; never wraps.
//     undefined:
//       - port and counter absent.
//       - all other behaviour identical.
//
// TESTING
//   1. WIDTH=1, sweep {a,b,bin} 000..111 at 10 ns steps.
//      Required d/bout: 000->0/0, 001->1/1, 010->1/1, 011->0/1,
//      100->1/0, 101->0/0, 110->0/0, 111->1/1.
//   2. Same sweep with in_valid=1 -> d_q/bout_q equal the previous cycle's
//      d/bout; out_valid=1 one cycle after the first valid.
//   3. rst_n=0 while out_valid=1 -> d_q=0, bout_q=0, out_valid=0
//      asynchronously; after release, first valid capture occurs normally.
//   4. WIDTH=4, a=4'h3, b=4'h5, bin=1 -> d=4'hD, bout=1;
//      a=4'hF, b=4'h0, bin=1 -> d=4'hE, bout=0.
//   5. in_valid toggles 1,0,1 -> out_valid follows 1,0,1 delayed one cycle;
//      d_q holds during the 0 cycle.
//   6. With FULL_SUBTRACTOR_BORROW_CNT_EN defined, run sweep 1 with
//      in_valid=1 -> borrow_cnt=4.

Source files
------------

// File: rtl/full_subtractor.sv
// WIDTH-bit ripple-borrow subtractor (a - b - bin) with a one-cycle registered copy.
// Optional borrow counter enabled by defining FULL_SUBTRACTOR_BORROW_CNT_EN.
module full_subtractor #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  input  logic             in_valid,
  output logic [WIDTH-1:0] d_q,
  output logic             bout_q,
`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
  output logic [15:0]      borrow_cnt,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   w_br;
  logic [WIDTH-1:0] w_d;

  always_comb begin
    w_br    = '0;
    w_d     = '0;
    w_br[0] = bin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_d[i]    = a[i] ^ b[i] ^ w_br[i];
      w_br[i+1] = (~a[i] & b[i]) | (~a[i] & w_br[i]) | (b[i] & w_br[i]);
    end
  end

  assign d    = w_d;
  assign bout = w_br[WIDTH];

  logic [WIDTH-1:0] r_d_q;
  logic             r_bout_q;
  logic             r_out_valid;

  // Result registers hold when in_valid is low; only the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_q       <= '0;
      r_bout_q    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_d_q    <= w_d;
        r_bout_q <= w_br[WIDTH];
      end
    end
  end

  assign d_q       = r_d_q;
  assign bout_q    = r_bout_q;
  assign out_valid = r_out_valid;

`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
  logic [15:0] r_borrow_cnt;

  // Saturating count of captured results that borrowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_borrow_cnt <= 16'h0000;
    end else if (in_valid && w_br[WIDTH] && (r_borrow_cnt != 16'hFFFF)) begin
      r_borrow_cnt <= r_borrow_cnt + 16'h0001;
    end
  end

  assign borrow_cnt = r_borrow_cnt;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Directed self-checking bench for full_subtractor (WIDTH=1 and WIDTH=4 instances).
module tb_full_subtractor;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, bin1, in_valid1;
  logic       d1, bout1, d_q1, bout_q1, out_valid1;
  logic [3:0] a4, b4, d4, d_q4;
  logic       bin4, bout4, bout_q4, out_valid4;
`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
  logic [15:0] borrow_cnt1, borrow_cnt4;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Hand-computed truth table indexed by {a,b,bin}.
  logic [7:0] d_tab    = 8'b1001_0110;
  logic [7:0] bout_tab = 8'b1000_1110;

  full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a1),
    .b         (b1),
    .bin       (bin1),
    .d         (d1),
    .bout      (bout1),
    .in_valid  (in_valid1),
    .d_q       (d_q1),
    .bout_q    (bout_q1),
`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
    .borrow_cnt(borrow_cnt1),
`endif
    .out_valid (out_valid1)
  );

  full_subtractor #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a4),
    .b         (b4),
    .bin       (bin4),
    .d         (d4),
    .bout      (bout4),
    .in_valid  (1'b0),
    .d_q       (d_q4),
    .bout_q    (bout_q4),
`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
    .borrow_cnt(borrow_cnt4),
`endif
    .out_valid (out_valid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic [2:0] v, input logic vld);
    {a1, b1, bin1} = v;
    in_valid1      = vld;
  endtask

  initial begin
    rst_n = 1'b0;
    drive1(3'b000, 1'b0);
    a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
    #12;
    check_val("rst_d_q", 32'(d_q1), 32'h0);
    check_val("rst_bout_q", 32'(bout_q1), 32'h0);
    check_val("rst_out_valid", 32'(out_valid1), 32'h0);
`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
    check_val("rst_borrow_cnt", 32'(borrow_cnt1), 32'h0);
`endif
    rst_n = 1'b1;

    // Sweep all {a,b,bin} with capture enabled; registered side lags one cycle.
    for (int v = 0; v < 8; v++) begin
      @(posedge clk);
      #1;
      if (v == 0) begin
        check_val("pipe_ov_first", 32'(out_valid1), 32'h0);
      end else begin
        check_val($sformatf("pipe_d_q_%0d", v - 1), 32'(d_q1), 32'(d_tab[v-1]));
        check_val($sformatf("pipe_bout_q_%0d", v - 1), 32'(bout_q1), 32'(bout_tab[v-1]));
        check_val($sformatf("pipe_ov_%0d", v), 32'(out_valid1), 32'h1);
      end
      drive1(3'(v), 1'b1);
      #1;
      check_val($sformatf("comb_d_%0d", v), 32'(d1), 32'(d_tab[v]));
      check_val($sformatf("comb_bout_%0d", v), 32'(bout1), 32'(bout_tab[v]));
    end
    @(posedge clk);
    #1;
    check_val("pipe_d_q_7", 32'(d_q1), 32'h1);
    check_val("pipe_bout_q_7", 32'(bout_q1), 32'h1);
    check_val("pipe_ov_7", 32'(out_valid1), 32'h1);
`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
    check_val("borrow_cnt_sweep", 32'(borrow_cnt1), 32'h4);
`endif

    // Asynchronous reset mid-stream, no clock edge in between.
    #1;
    rst_n = 1'b0;
    #1;
    check_val("arst_d_q", 32'(d_q1), 32'h0);
    check_val("arst_bout_q", 32'(bout_q1), 32'h0);
    check_val("arst_out_valid", 32'(out_valid1), 32'h0);
    #1;
    rst_n = 1'b1;
    drive1(3'b100, 1'b1);
    @(posedge clk);
    #1;
    check_val("post_rst_d_q", 32'(d_q1), 32'h1);
    check_val("post_rst_bout_q", 32'(bout_q1), 32'h0);
    check_val("post_rst_ov", 32'(out_valid1), 32'h1);

    // WIDTH=4 combinational vectors.
    a4 = 4'h3; b4 = 4'h5; bin4 = 1'b1;
    #1;
    check_val("w4_d_a", 32'(d4), 32'hD);
    check_val("w4_bout_a", 32'(bout4), 32'h1);
    a4 = 4'hF; b4 = 4'h0; bin4 = 1'b1;
    #1;
    check_val("w4_d_b", 32'(d4), 32'hE);
    check_val("w4_bout_b", 32'(bout4), 32'h0);
    a4 = 4'h0; b4 = 4'h0; bin4 = 1'b1;
    #1;
    check_val("w4_d_c", 32'(d4), 32'hF);
    check_val("w4_bout_c", 32'(bout4), 32'h1);
    a4 = 4'h8; b4 = 4'h3; bin4 = 1'b0;
    #1;
    check_val("w4_d_d", 32'(d4), 32'h5);
    check_val("w4_bout_d", 32'(bout4), 32'h0);

    // in_valid 1,0,1: valid follows one cycle later, data holds in the gap.
    @(posedge clk);
    #1;
    drive1(3'b111, 1'b1);
    @(posedge clk);
    #1;
    check_val("tog1_ov", 32'(out_valid1), 32'h1);
    check_val("tog1_d_q", 32'(d_q1), 32'h1);
    check_val("tog1_bout_q", 32'(bout_q1), 32'h1);
    drive1(3'b000, 1'b0);
    @(posedge clk);
    #1;
    check_val("tog0_ov", 32'(out_valid1), 32'h0);
    check_val("tog0_d_q_hold", 32'(d_q1), 32'h1);
    check_val("tog0_bout_q_hold", 32'(bout_q1), 32'h1);
    drive1(3'b011, 1'b1);
    @(posedge clk);
    #1;
    check_val("tog2_ov", 32'(out_valid1), 32'h1);
    check_val("tog2_d_q", 32'(d_q1), 32'h0);
    check_val("tog2_bout_q", 32'(bout_q1), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
